// File: rtl/mux4a1_rr_cond_if.sv
// Lane-side and stream-side signal bundle for the 4:1 round-robin recombiner.
// master: upstream lanes / stream consumer side; slave: the recombiner itself.
// Lane N: validN/data_inN in, readyN out; stream: valid_out/data_out/lane_out.
interface mux4a1_rr_cond_if #(
    parameter int BW = 8
);
    logic          valid0, valid1, valid2, valid3;
    logic [BW-1:0] data_in0, data_in1, data_in2, data_in3;
    logic          ready0, ready1, ready2, ready3;
    logic          valid_out;
    logic [BW-1:0] data_out;
    logic [1:0]    lane_out;

    modport master (
        output valid0, valid1, valid2, valid3,
        output data_in0, data_in1, data_in2, data_in3,
        input  ready0, ready1, ready2, ready3,
        input  valid_out, data_out, lane_out
    );

    modport slave (
        input  valid0, valid1, valid2, valid3,
        input  data_in0, data_in1, data_in2, data_in3,
        output ready0, ready1, ready2, ready3,
        output valid_out, data_out, lane_out
    );
endinterface

// File: rtl/mux4a1_rr_cond.sv
// Recombines four lanes into one stream, draining lanes strictly in order 0,1,2,3.
// Latency: word accepted at edge k is on data_out after edge k+1 at the earliest.
// Backpressure: readyN drops while lane N holds an undrained word and is not the current turn.
// Ports: clk, reset_L (async active-low), bus (slave modport): lane valid/data in, lane ready out,
//        valid_out/data_out/lane_out registered stream out.
module mux4a1_rr_cond #(
    parameter int BW = 8
) (
    input  logic            clk,
    input  logic            reset_L,
    mux4a1_rr_cond_if.slave bus
);
    logic [3:0]         vld;
    logic [3:0][BW-1:0] din;
    logic [3:0]         rdy;
    logic [3:0]         acc;
    logic               drain;

    logic [3:0]         full_q, full_d;
    logic [3:0][BW-1:0] hold_q, hold_d;
    logic [1:0]         sel_q, sel_d;
    logic               vout_q, vout_d;
    logic [BW-1:0]      dout_q, dout_d;
    logic [1:0]         lane_q, lane_d;

    assign vld = {bus.valid3, bus.valid2, bus.valid1, bus.valid0};
    assign din = {bus.data_in3, bus.data_in2, bus.data_in1, bus.data_in0};

    // The lane currently being drained may always accept: its holding register
    // empties on the same edge if it is full, so a refill never overwrites a live word.
    always_comb begin
        rdy = '0;
        for (int n = 0; n < 4; n++) begin
            rdy[n] = !full_q[n] || (sel_q == 2'(n));
        end
    end

    assign acc   = vld & rdy;
    assign drain = full_q[sel_q];

    always_comb begin
        full_d = full_q;
        hold_d = hold_q;
        sel_d  = sel_q;
        vout_d = 1'b0;
        dout_d = dout_q;
        lane_d = lane_q;

        if (drain) begin
            vout_d        = 1'b1;
            dout_d        = hold_q[sel_q];
            lane_d        = sel_q;
            full_d[sel_q] = 1'b0;
            sel_d         = sel_q + 2'd1;
        end

        // Accept after drain so a same-edge refill of the drained lane keeps it full.
        for (int n = 0; n < 4; n++) begin
            if (acc[n]) begin
                full_d[n] = 1'b1;
                hold_d[n] = din[n];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            full_q <= '0;
            hold_q <= '0;
            sel_q  <= '0;
            vout_q <= 1'b0;
            dout_q <= '0;
            lane_q <= '0;
        end else begin
            full_q <= full_d;
            hold_q <= hold_d;
            sel_q  <= sel_d;
            vout_q <= vout_d;
            dout_q <= dout_d;
            lane_q <= lane_d;
        end
    end

    assign bus.ready0    = rdy[0];
    assign bus.ready1    = rdy[1];
    assign bus.ready2    = rdy[2];
    assign bus.ready3    = rdy[3];
    assign bus.valid_out = vout_q;
    assign bus.data_out  = dout_q;
    assign bus.lane_out  = lane_q;
endmodule

// File: tb/tb_mux4a1_rr_cond.sv
module tb_mux4a1_rr_cond;
    logic clk;
    logic reset_L;
    int   n_tests = 0;
    int   n_fail  = 0;

    mux4a1_rr_cond_if #(.BW(8)) bus ();

    mux4a1_rr_cond #(.BW(8)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] vld;
        logic [7:0] d0, d1, d2, d3;
        logic       e_vout;
        logic [7:0] e_dout;
        logic [1:0] e_lane;
        logic [3:0] e_rdy;
    } vec_t;

    vec_t vt [19];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] rdy_vec();
        return {bus.ready3, bus.ready2, bus.ready1, bus.ready0};
    endfunction

    task automatic drive(input logic [3:0] v, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        bus.valid0   = v[0];
        bus.valid1   = v[1];
        bus.valid2   = v[2];
        bus.valid3   = v[3];
        bus.data_in0 = a;
        bus.data_in1 = b;
        bus.data_in2 = c;
        bus.data_in3 = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [7:0] d, input logic [1:0] l);
        chk({name, "_vld"}, 16'(bus.valid_out), 16'(v));
        if (v) begin
            chk({name, "_dat"}, 16'(bus.data_out), 16'(d));
            chk({name, "_lane"}, 16'(bus.lane_out), 16'(l));
        end
    endtask

    task automatic do_reset();
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        reset_L = 1'b0;
        tick();
        tick();
        @(negedge clk);
        reset_L = 1'b1;
        tick();
    endtask

    logic [7:0] sbq [4][$];
    logic [5:0] cnt [4];
    logic [3:0] sv;
    logic [7:0] sd [4];
    int         exp_lane;
    int         n_in, n_out;
    bit         started;
    int         pending;

    initial begin
        vt[0]  = '{4'b1111, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 1'b0, 8'h00, 2'd0, 4'b1111};
        vt[1]  = '{4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 2'd0, 4'b0001};
        vt[2]  = '{4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'hAA, 2'd0, 4'b0011};
        vt[3]  = '{4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'hBB, 2'd1, 4'b0111};
        vt[4]  = '{4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'hCC, 2'd2, 4'b1111};
        vt[5]  = '{4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'hDD, 2'd3, 4'b1111};
        vt[6]  = '{4'b1101, 8'h11, 8'h00, 8'h33, 8'h44, 1'b0, 8'hDD, 2'd3, 4'b1111};
        vt[7]  = '{4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'hDD, 2'd3, 4'b0011};
        vt[8]  = '{4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h11, 2'd0, 4'b0011};
        vt[9]  = '{4'b0100, 8'h00, 8'h00, 8'h99, 8'h00, 1'b0, 8'h11, 2'd0, 4'b0011};
        vt[10] = '{4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h11, 2'd0, 4'b0011};
        vt[11] = '{4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h11, 2'd0, 4'b0011};
        vt[12] = '{4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h11, 2'd0, 4'b0011};
        vt[13] = '{4'b0010, 8'h00, 8'h22, 8'h00, 8'h00, 1'b0, 8'h11, 2'd0, 4'b0011};
        vt[14] = '{4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h11, 2'd0, 4'b0011};
        vt[15] = '{4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h22, 2'd1, 4'b0111};
        vt[16] = '{4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h33, 2'd2, 4'b1111};
        vt[17] = '{4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h44, 2'd3, 4'b1111};
        vt[18] = '{4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h44, 2'd3, 4'b1111};

        // Reset held with random lane activity.
        reset_L = 1'b1;
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        #2 reset_L = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            tick();
            chk("rst_vld", 16'(bus.valid_out), 16'd0);
            chk("rst_dat", 16'(bus.data_out), 16'd0);
            chk("rst_lane", 16'(bus.lane_out), 16'd0);
            chk("rst_rdy", 16'(rdy_vec()), 16'hF);
        end
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        reset_L = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_vld", 16'(bus.valid_out), 16'd0);
        end

        // Single batch and stall, table-driven.
        for (int i = 0; i < 19; i++) begin
            drive(vt[i].vld, vt[i].d0, vt[i].d1, vt[i].d2, vt[i].d3);
            chk($sformatf("vec%0d_vld", i), 16'(bus.valid_out), 16'(vt[i].e_vout));
            chk($sformatf("vec%0d_dat", i), 16'(bus.data_out), 16'(vt[i].e_dout));
            chk($sformatf("vec%0d_lane", i), 16'(bus.lane_out), 16'(vt[i].e_lane));
            chk($sformatf("vec%0d_rdy", i), 16'(rdy_vec()), 16'(vt[i].e_rdy));
            tick();
        end

        // Streaming: every lane injects whenever ready.
        do_reset();
        for (int n = 0; n < 4; n++) cnt[n] = '0;
        exp_lane = 0;
        n_in = 0;
        n_out = 0;
        started = 0;
        for (int c = 0; c < 50; c++) begin
            pending = sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size();
            if (bus.valid_out) begin
                started = 1;
                n_out++;
                chk("stream_lane", 16'(bus.lane_out), 16'(exp_lane));
                if (sbq[exp_lane].size() == 0) begin
                    chk("stream_extra", 16'(bus.valid_out), 16'd0);
                end else begin
                    chk("stream_dat", 16'(bus.data_out), 16'(sbq[exp_lane].pop_front()));
                end
                exp_lane = (exp_lane + 1) % 4;
            end else if (started && pending != 0) begin
                chk("stream_bubble", 16'(bus.valid_out), 16'd1);
            end
            sv = rdy_vec();
            for (int n = 0; n < 4; n++) begin
                sd[n] = 8'h00;
                if (c < 40 && sv[n]) begin
                    sd[n] = {2'(n), cnt[n]};
                    sbq[n].push_back(sd[n]);
                    cnt[n] = cnt[n] + 6'd1;
                    n_in++;
                end else begin
                    sv[n] = 1'b0;
                end
            end
            drive(sv, sd[0], sd[1], sd[2], sd[3]);
            tick();
        end
        chk("stream_count", 16'(n_out), 16'(n_in));
        chk("stream_left", 16'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 16'd0);

        // Drain and refill lane 2 on the same edge.
        do_reset();
        drive(4'b0111, 8'h01, 8'h02, 8'h5A, 8'h00);
        tick();
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        chk_out("rf_w0", 1'b1, 8'h01, 2'd0);
        tick();
        chk_out("rf_w1", 1'b1, 8'h02, 2'd1);
        chk("rf_rdy2_turn", 16'(bus.ready2), 16'd1);
        drive(4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00);
        tick();
        chk_out("rf_5a", 1'b1, 8'h5A, 2'd2);
        chk("rf_full2", 16'(bus.ready2), 16'd0);
        drive(4'b1011, 8'hB0, 8'hB1, 8'h00, 8'hB3);
        tick();
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        chk_out("rf_stall", 1'b0, 8'h00, 2'd0);
        tick();
        chk_out("rf_b3", 1'b1, 8'hB3, 2'd3);
        tick();
        chk_out("rf_b0", 1'b1, 8'hB0, 2'd0);
        tick();
        chk_out("rf_b1", 1'b1, 8'hB1, 2'd1);
        tick();
        chk_out("rf_a5", 1'b1, 8'hA5, 2'd2);
        tick();
        chk_out("rf_end", 1'b0, 8'h00, 2'd0);

        // Asynchronous reset with three lanes still full.
        do_reset();
        drive(4'b1111, 8'h61, 8'h62, 8'h63, 8'h64);
        tick();
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        chk_out("mr_pre", 1'b1, 8'h61, 2'd0);
        #3 reset_L = 1'b0;
        #1;
        chk("mr_vld_now", 16'(bus.valid_out), 16'd0);
        chk("mr_dat_now", 16'(bus.data_out), 16'd0);
        chk("mr_rdy_now", 16'(rdy_vec()), 16'hF);
        tick();
        tick();
        @(negedge clk);
        reset_L = 1'b1;
        tick();
        chk_out("mr_post0", 1'b0, 8'h00, 2'd0);
        tick();
        chk_out("mr_post1", 1'b0, 8'h00, 2'd0);
        drive(4'b1111, 8'h71, 8'h72, 8'h73, 8'h74);
        tick();
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        chk_out("mr_fill", 1'b0, 8'h00, 2'd0);
        tick();
        chk_out("mr_first", 1'b1, 8'h71, 2'd0);
        tick();
        chk_out("mr_second", 1'b1, 8'h72, 2'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
